// File: rtl/qoi_op_index_decoder.sv
// qoi_op_index_decoder: turns QOI_OP_INDEX bytes back into pixels using the
// 64-entry previously-seen-pixel table, which is refreshed from every pixel
// the wider decoder emits (seen_pixel/seen_valid).
// Optional build macro: QOI_INDEX_STATS_EN adds index_hits / miss_count
// saturating counters. Default build (macro undefined) omits them.
module qoi_op_index_decoder #(
    parameter int unsigned COMPONENTS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    input  logic [8*COMPONENTS-1:0] seen_pixel,
    input  logic                    seen_valid,
    output logic [8*COMPONENTS-1:0] pixel,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic                    tag_miss
`ifdef QOI_INDEX_STATS_EN
    ,
    output logic [31:0]             index_hits,
    output logic [31:0]             miss_count
`endif
);

    localparam int unsigned PIX_W  = 8 * COMPONENTS;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned HASH_W = 12;
    localparam logic [1:0]  TAG_INDEX = 2'b00;

    // QOI colour hash; alpha is implied opaque when the stream carries RGB only
    function automatic logic [IDX_W-1:0] qoi_hash(input logic [PIX_W-1:0] p);
        logic [HASH_W-1:0] r;
        logic [HASH_W-1:0] g;
        logic [HASH_W-1:0] b;
        logic [HASH_W-1:0] a;
        logic [HASH_W-1:0] s;
        r = HASH_W'(p[PIX_W-1  -: 8]);
        g = HASH_W'(p[PIX_W-9  -: 8]);
        b = HASH_W'(p[PIX_W-17 -: 8]);
        a = (COMPONENTS == 4) ? HASH_W'(p[7:0]) : HASH_W'(8'hFF);
        s = r * HASH_W'(3) + g * HASH_W'(5) + b * HASH_W'(7) + a * HASH_W'(11);
        return s[IDX_W-1:0];
    endfunction

    logic [PIX_W-1:0] table_q [DEPTH];
    logic [PIX_W-1:0] table_d [DEPTH];
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             tag_miss_q, tag_miss_d;

    logic             accept;
    logic             accept_index;
    logic             accept_miss;
    logic [IDX_W-1:0] seen_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [PIX_W-1:0] rd_data;

    // Input acceptance: a new byte may enter whenever the output slot frees up
    always_comb begin
        byte_ready   = !pixel_valid_q || pixel_ready;
        accept       = byte_valid && byte_ready;
        accept_index = accept && (byte_in[7:6] == TAG_INDEX);
        accept_miss  = accept && (byte_in[7:6] != TAG_INDEX);
        seen_idx     = qoi_hash(seen_pixel);
        rd_idx       = byte_in[IDX_W-1:0];
    end

    // Table read with write-first bypass so a same-cycle update is never missed
    always_comb begin
        rd_data = table_q[rd_idx];
        if (seen_valid && (seen_idx == rd_idx)) begin
            rd_data = seen_pixel;
        end
    end

    // Table next state: one entry rewritten per seen pixel, independent of handshakes
    always_comb begin
        table_d = table_q;
        if (seen_valid) begin
            table_d[seen_idx] = seen_pixel;
        end
    end

    // Output slot next state: handshake drains, an accepted INDEX byte reloads
    always_comb begin
        pixel_d       = pixel_q;
        pixel_valid_d = pixel_valid_q;
        tag_miss_d    = accept_miss;
        if (pixel_valid_q && pixel_ready) begin
            pixel_valid_d = 1'b0;
        end
        if (accept_index) begin
            pixel_d       = rd_data;
            pixel_valid_d = 1'b1;
        end
    end

    // Pixel table registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            tag_miss_q    <= 1'b0;
        end else begin
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            tag_miss_q    <= tag_miss_d;
        end
    end

    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign tag_miss    = tag_miss_q;

`ifdef QOI_INDEX_STATS_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] index_hits_q, index_hits_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    // Saturating event counters; a miss counts on the same edge its pulse rises
    always_comb begin
        index_hits_d = index_hits_q;
        miss_count_d = miss_count_q;
        if (accept_index && (index_hits_q != '1)) begin
            index_hits_d = index_hits_q + CNT_W'(1);
        end
        if (accept_miss && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_hits_q <= '0;
            miss_count_q <= '0;
        end else begin
            index_hits_q <= index_hits_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign index_hits = index_hits_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_qoi_op_index_decoder.sv
// Directed self-checking bench for qoi_op_index_decoder (COMPONENTS = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_qoi_op_index_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] seen_pixel;
    logic        seen_valid;
    logic [31:0] pixel;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        tag_miss;
`ifdef QOI_INDEX_STATS_EN
    logic [31:0] index_hits;
    logic [31:0] miss_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_hits = 0;

    always #5 clk = ~clk;

    qoi_op_index_decoder #(.COMPONENTS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .seen_pixel  (seen_pixel),
        .seen_valid  (seen_valid),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .tag_miss    (tag_miss)
`ifdef QOI_INDEX_STATS_EN
        ,
        .index_hits  (index_hits),
        .miss_count  (miss_count)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        seen_pixel = 32'h0; seen_valid = 1'b0; pixel_ready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pixel_valid); else pass_cnt++;
        total_cnt++;
        if (pixel !== 32'h0) $display("FAIL reset_pixel: got %h want 00000000", pixel); else pass_cnt++;
        total_cnt++;
        if (tag_miss !== 1'b0) $display("FAIL reset_tag_miss: got %b want 0", tag_miss); else pass_cnt++;
        total_cnt++;
        if (byte_ready !== 1'b1) $display("FAIL reset_byte_ready: got %b want 1", byte_ready); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_lookup();
        @(negedge clk);
        byte_in = 8'h05; byte_valid = 1'b1; pixel_ready = 1'b1; exp_hits++;
        @(negedge clk);
        byte_valid = 1'b0;
        total_cnt++;
        if (pixel_valid !== 1'b1) $display("FAIL lookup_valid: got %b want 1", pixel_valid); else pass_cnt++;
        total_cnt++;
        if (pixel !== 32'h0) $display("FAIL lookup_pixel: got %h want 00000000", pixel); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL lookup_drain: got %b want 0", pixel_valid); else pass_cnt++;
    endtask

    task automatic test_table_update();
        seen_pixel = 32'h102030FF; seen_valid = 1'b1;
        @(negedge clk);
        seen_valid = 1'b0;
        byte_in = 8'h15; byte_valid = 1'b1; exp_hits++;
        @(negedge clk);
        total_cnt++;
        if (pixel !== 32'h102030FF || pixel_valid !== 1'b1)
            $display("FAIL update_idx21: got %h/%b want 102030ff/1", pixel, pixel_valid);
        else pass_cnt++;
        byte_in = 8'h35; exp_hits++;
        @(negedge clk);
        byte_valid = 1'b0;
        total_cnt++;
        if (pixel !== 32'h0 || pixel_valid !== 1'b1)
            $display("FAIL update_idx53: got %h/%b want 00000000/1", pixel, pixel_valid);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        seen_pixel = 32'h000000FF; seen_valid = 1'b1;
        byte_in = 8'h35; byte_valid = 1'b1; exp_hits++;
        @(negedge clk);
        seen_valid = 1'b0; byte_valid = 1'b0;
        total_cnt++;
        if (pixel !== 32'h000000FF || pixel_valid !== 1'b1)
            $display("FAIL bypass_pixel: got %h/%b want 000000ff/1", pixel, pixel_valid);
        else pass_cnt++;
        @(negedge clk);
        byte_in = 8'h35; byte_valid = 1'b1; exp_hits++;
        @(negedge clk);
        byte_valid = 1'b0;
        total_cnt++;
        if (pixel !== 32'h000000FF) $display("FAIL bypass_written: got %h want 000000ff", pixel); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_tag_miss();
        byte_in = 8'hFE; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        total_cnt++;
        if (tag_miss !== 1'b1) $display("FAIL miss_pulse: got %b want 1", tag_miss); else pass_cnt++;
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL miss_no_pixel: got %b want 0", pixel_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (tag_miss !== 1'b0) $display("FAIL miss_one_cycle: got %b want 0", tag_miss); else pass_cnt++;
`ifdef QOI_INDEX_STATS_EN
        total_cnt++;
        if (miss_count !== 32'd1) $display("FAIL miss_count: got %0d want 1", miss_count); else pass_cnt++;
        total_cnt++;
        if (index_hits !== 32'(exp_hits)) $display("FAIL index_hits: got %0d want %0d", index_hits, exp_hits); else pass_cnt++;
`endif
    endtask

    task automatic test_backpressure();
        byte_in = 8'h15; byte_valid = 1'b1; pixel_ready = 1'b0; exp_hits++;
        @(negedge clk);
        byte_in = 8'h35;
        #1;
        total_cnt++;
        if (pixel !== 32'h102030FF || pixel_valid !== 1'b1)
            $display("FAIL bp_first: got %h/%b want 102030ff/1", pixel, pixel_valid);
        else pass_cnt++;
        total_cnt++;
        if (byte_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", byte_ready); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if (pixel !== 32'h102030FF || pixel_valid !== 1'b1 || byte_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got %h/%b/%b want 102030ff/1/0", i, pixel, pixel_valid, byte_ready);
            else pass_cnt++;
        end
        @(negedge clk);
        pixel_ready = 1'b1; exp_hits++;
        #1;
        total_cnt++;
        if (byte_ready !== 1'b1) $display("FAIL bp_ready_high: got %b want 1", byte_ready); else pass_cnt++;
        @(negedge clk);
        byte_valid = 1'b0;
        total_cnt++;
        if (pixel !== 32'h000000FF || pixel_valid !== 1'b1)
            $display("FAIL bp_queued: got %h/%b want 000000ff/1", pixel, pixel_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", pixel_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // Each pixel lands in a distinct slot: hashes 3,5,7,11,22,6,10,14
        logic [31:0] pix [8];
        logic [5:0]  idx [8];
        pix[0] = 32'h01000000; idx[0] = 6'd3;
        pix[1] = 32'h00010000; idx[1] = 6'd5;
        pix[2] = 32'h00000100; idx[2] = 6'd7;
        pix[3] = 32'h00000001; idx[3] = 6'd11;
        pix[4] = 32'h00000002; idx[4] = 6'd22;
        pix[5] = 32'h02000000; idx[5] = 6'd6;
        pix[6] = 32'h00020000; idx[6] = 6'd10;
        pix[7] = 32'h00000200; idx[7] = 6'd14;
        for (int i = 0; i < 8; i++) begin
            seen_pixel = pix[i]; seen_valid = 1'b1;
            @(negedge clk);
        end
        seen_valid = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                byte_in = {2'b00, idx[i]}; byte_valid = 1'b1; exp_hits++;
            end else begin
                byte_valid = 1'b0;
            end
            if (i > 0) begin
                total_cnt++;
                if (pixel !== pix[i-1] || pixel_valid !== 1'b1)
                    $display("FAIL b2b_%0d: got %h/%b want %h/1", i - 1, pixel, pixel_valid, pix[i-1]);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", pixel_valid); else pass_cnt++;
`ifdef QOI_INDEX_STATS_EN
        total_cnt++;
        if (index_hits !== 32'(exp_hits)) $display("FAIL b2b_hits: got %0d want %0d", index_hits, exp_hits); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_stream();
        byte_in = 8'h03; byte_valid = 1'b1;
        @(negedge clk);
        byte_in = 8'h05;
        @(negedge clk);
        total_cnt++;
        if (pixel !== 32'h00010000 || pixel_valid !== 1'b1)
            $display("FAIL mid_pre_reset: got %h/%b want 00010000/1", pixel, pixel_valid);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL mid_reset_async: got %b want 0", pixel_valid); else pass_cnt++;
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        byte_in = 8'h03; byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        total_cnt++;
        if (pixel !== 32'h0 || pixel_valid !== 1'b1)
            $display("FAIL mid_after_reset: got %h/%b want 00000000/1", pixel, pixel_valid);
        else pass_cnt++;
`ifdef QOI_INDEX_STATS_EN
        total_cnt++;
        if (miss_count !== 32'd0 || index_hits !== 32'd1)
            $display("FAIL mid_stats: got %0d/%0d want 0/1", miss_count, index_hits);
        else pass_cnt++;
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_lookup();
        test_table_update();
        test_bypass();
        test_tag_miss();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/qoi_op_index_decoder.md
Name: qoi_op_index_decoder

Overview:
Decodes QOI_OP_INDEX bytes (tag 2'b00, payload = 6-bit index) from the QOI byte stream back into pixels. It keeps the 64-entry previously-seen-pixel array, which it updates from every pixel the wider decoder emits. It is the receive-side counterpart of the QOI_OP_INDEX encoder and sits beside the RGB/RGBA/DIFF/LUMA/RUN decoders, feeding the pixel output mux.

Parameters:
COMPONENTS, 4, image components: 4 = RGBA, 3 = RGB (alpha implied 8'hFF for hashing).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
byte_in  input  8  QOI stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  decoder can accept byte_in this cycle
seen_pixel  input  8*COMPONENTS  pixel emitted by any decoder path, for table update
seen_valid  input  1  seen_pixel valid this cycle
pixel  output  8*COMPONENTS  decoded pixel {r,g,b[,a]}, r in MSBs
pixel_valid  output  1  pixel holds a decoded pixel
pixel_ready  input  1  downstream accepts pixel
tag_miss  output  1  one-cycle pulse: accepted byte was not an INDEX op

Behaviour:
- Reset (async, rst_n=0): all 64 table entries = 0; pixel=0; pixel_valid=0; tag_miss=0. A reset mid-transfer drops any held pixel immediately.
- byte_ready = !pixel_valid || pixel_ready (combinational). A byte is accepted when byte_valid && byte_ready.
- Accepted byte with byte_in[7:6]==2'b00: next cycle pixel = table[byte_in[5:0]] and pixel_valid=1. Latency is 1 cycle.
- Accepted byte with another tag: byte is dropped; tag_miss=1 for exactly one cycle; pixel/pixel_valid are unchanged unless a handshake clears them.
- Output handshake: pixel_valid && pixel_ready clears pixel_valid next cycle unless a new INDEX byte is accepted in the same cycle, in which case the output reloads back-to-back (1 pixel/cycle sustained). While pixel_valid && !pixel_ready, pixel holds stable and byte_ready=0.
- Hash: h = (r*3 + g*5 + b*7 + a*11) mod 64, computed combinationally at 12-bit width, low 6 bits kept. For COMPONENTS=3, a = 8'hFF.
- Table update: on seen_valid, table[h(seen_pixel)] <= seen_pixel at that edge. Update is independent of byte handshake and backpressure.
- Same-cycle write/read: if seen_valid and an INDEX byte is accepted in the same cycle and h(seen_pixel)==byte_in[5:0], the output takes seen_pixel (write-first bypass), not the stale entry.
- Pixels produced here are not auto-written back; the top level routes pixel into seen_pixel like every other path.

Optional Feature:
QOI_INDEX_STATS_EN:
- Defined: adds output index_hits [31:0], reset 0, incremented on each accepted INDEX byte, saturating at 32'hFFFF_FFFF. Adds output miss_count [31:0] with the same rules on tag_miss.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then byte_in=8'h05 valid, pixel_ready=1 -> next cycle pixel_valid=1, pixel=32'h0000_0000; the following cycle pixel_valid=0.
- seen_pixel=32'h102030FF seen_valid=1; later byte_in=8'h15 (index 21) -> pixel=32'h102030FF. Then byte_in=8'h35 (index 53) -> 0.
- Same-cycle: seen_pixel=32'h000000FF (hash 53) with byte_in=8'h35 -> pixel=32'h000000FF via bypass.
- byte_in=8'hFE accepted -> tag_miss pulses 1 cycle, pixel_valid stays 0. With STATS_EN, miss_count=1 and index_hits unchanged.
- Backpressure: pixel_ready=0 for 3 cycles after an INDEX output -> pixel stable, byte_ready=0, next byte not consumed. pixel_ready=1 -> handshake, and the queued byte produces the next pixel one cycle later.
- Stream of 8 consecutive INDEX bytes with pixel_ready=1 -> 8 pixels on 8 consecutive cycles. Assert rst_n=0 mid-stream -> pixel_valid=0 immediately; a lookup after release returns 0.
